// File: rtl/ooo_pkg.sv
// Shared out-of-order core sizing: physical/architectural register counts and tag/pointer types.
// The physical register file and the rename map table use the same definitions.
package ooo_pkg;

   localparam int unsigned NUM_PHYS_REGS = 64;
   localparam int unsigned NUM_ARCH_REGS = 32;
   localparam int unsigned PW            = $clog2(NUM_PHYS_REGS);

   typedef logic [PW-1:0] preg_tag_t;
   // One extra wrap bit so that a full list and an empty list are distinguishable.
   typedef logic [PW:0]   ptr_t;

endpackage

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags: dual show-ahead allocation, dual release at
// retire, and a committed head that a flush restores allocation to.
module phys_reg_free_list
   import ooo_pkg::*;
(
   input  logic          CLK,
   input  logic          RESET,
   input  logic          AllocReq1_IN,
   input  logic          AllocReq2_IN,
   output logic [PW-1:0] AllocReg1_OUT,
   output logic [PW-1:0] AllocReg2_OUT,
   output logic          AllocGrant_OUT,
   input  logic          FreeEnable1_IN,
   input  logic [PW-1:0] FreeReg1_IN,
   input  logic          FreeEnable2_IN,
   input  logic [PW-1:0] FreeReg2_IN,
   input  logic [1:0]    CommitCount_IN,
   input  logic          Flush_IN,
   output logic [PW:0]   FreeCount_OUT
);

   localparam int unsigned NUM_INIT = NUM_PHYS_REGS - NUM_ARCH_REGS;

   preg_tag_t  list_q [NUM_PHYS_REGS];
   ptr_t       head_q, head_d;
   ptr_t       commit_head_q, commit_head_d;
   ptr_t       tail_q, tail_d;
   ptr_t       count;
   logic [1:0] need;
   logic [1:0] nfree;
   logic       grant;
   preg_tag_t  head_idx, head_idx1;
   preg_tag_t  tail_idx, tail_idx1;
   logic       wr_a_en, wr_b_en;
   preg_tag_t  wr_a_data;

   assign head_idx  = head_q[PW-1:0];
   assign head_idx1 = head_q[PW-1:0] + preg_tag_t'(1);
   assign tail_idx  = tail_q[PW-1:0];
   assign tail_idx1 = tail_q[PW-1:0] + preg_tag_t'(1);

   always_comb begin
      need  = {1'b0, AllocReq1_IN} + {1'b0, AllocReq2_IN};
      nfree = {1'b0, FreeEnable1_IN} + {1'b0, FreeEnable2_IN};
      // Count uses the registered tail, so tags freed this cycle are not yet allocatable.
      count = tail_q - head_q;
      grant = (need != 2'd0) && !Flush_IN && (ptr_t'(need) <= count);

      commit_head_d = commit_head_q + ptr_t'(CommitCount_IN);
      tail_d        = tail_q + ptr_t'(nfree);
      head_d        = head_q;
      if (Flush_IN) begin
         head_d = commit_head_d;
      end else if (grant) begin
         head_d = head_q + ptr_t'(need);
      end
   end

   // A lone release on port 2 takes the tail slot, keeping the written entries contiguous.
   always_comb begin
      wr_a_en   = FreeEnable1_IN | FreeEnable2_IN;
      wr_a_data = FreeEnable1_IN ? FreeReg1_IN : FreeReg2_IN;
      wr_b_en   = FreeEnable1_IN & FreeEnable2_IN;
   end

   always_comb begin
      AllocReg1_OUT  = list_q[head_idx];
      AllocReg2_OUT  = AllocReq1_IN ? list_q[head_idx1] : list_q[head_idx];
      AllocGrant_OUT = grant;
      FreeCount_OUT  = count;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         head_q        <= '0;
         commit_head_q <= '0;
         tail_q        <= ptr_t'(NUM_INIT);
      end else begin
         head_q        <= head_d;
         commit_head_q <= commit_head_d;
         tail_q        <= tail_d;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int unsigned i = 0; i < NUM_PHYS_REGS; i++) begin
            list_q[i] <= (i < NUM_INIT) ? preg_tag_t'(NUM_ARCH_REGS + i) : '0;
         end
      end else begin
         if (wr_a_en) begin
            list_q[tail_idx] <= wr_a_data;
         end
         if (wr_b_en) begin
            list_q[tail_idx1] <= FreeReg2_IN;
         end
      end
   end

`ifndef SYNTHESIS
   always @(posedge CLK) begin
      if (RESET) begin
         assert (ptr_t'(tail_d - head_d) <= ptr_t'(NUM_PHYS_REGS))
            else $error("phys_reg_free_list: release overflows the free list");
      end
   end
`endif

endmodule
